// File: rtl/seq_divider_pkg.sv
// seq_divider shared constants: state encodings, default widths, DBZ result.
package seq_divider_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;
  localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_DBZ  = 2'd3;

  localparam logic [7:0] DBZ_QUOT = 8'hFF;

endpackage

// File: rtl/seq_divider_datapath.sv
// Restoring-division datapath: Q/R/B registers, compare-subtract and
// result registers, driven by load/step/commit strobes from the FSM.
module seq_divider_datapath
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  commit,
  input  logic                  dbz_commit,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
);

  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W:0]    r;
  logic [DIVISOR_W-1:0]  b;

  logic [DIVISOR_W:0]    r_shift;
  logic [DIVISOR_W:0]    r_next;
  logic [DIVIDEND_W-1:0] q_next;
  logic                  ge;

  // R is one bit wider than B so the shifted value up to 2B-1 fits.
  always_comb begin
    r_shift = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    ge      = r_shift >= {1'b0, b};
    r_next  = ge ? (r_shift - {1'b0, b}) : r_shift;
    q_next  = {q[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      r <= '0;
      b <= '0;
    end else if (load) begin
      q <= dividend;
      r <= '0;
      b <= divisor;
    end else if (step) begin
      q <= q_next;
      r <= r_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (load) begin
      dbz <= 1'b0;
    end else if (commit) begin
      quotient  <= q_next;
      remainder <= r_next[DIVISOR_W-1:0];
    end else if (dbz_commit) begin
      quotient  <= '1;
      remainder <= q[DIVISOR_W-1:0];
      dbz       <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional fast divide-by-zero path: define SEQ_DIVIDER_DBZ_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ready,
  output logic                  dbz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             commit;
  logic             dbz_commit;
  logic             zero_div;

`ifdef SEQ_DIVIDER_DBZ_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign ready = (state == S_IDLE) || (state == S_DONE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    dbz_commit = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = zero_div ? S_DBZ : S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DBZ: begin
        dbz_commit = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load)
        cnt <= CNT_W'(DIVIDEND_W - 1);
      else if (step)
        cnt <= cnt - 1'b1;
    end
  end

  seq_divider_datapath #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (DIVISOR_W)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .commit    (commit),
    .dbz_commit(dbz_commit),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider; honours SEQ_DIVIDER_DBZ_EN if defined.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       ready;
  logic       dbz;

  int checks   = 0;
  int failures = 0;

  seq_divider dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .ready    (ready),
    .dbz      (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then count edges until ready returns.
  task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                        output int lat);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("ready_low_after_accept", 32'(ready), 0);
    lat = 0;
    while (!ready && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_ready", 32'(ready), 1);
    check("reset_quot",  32'(quotient), 0);
    check("reset_rem",   32'(remainder), 0);
    check("reset_dbz",   32'(dbz), 0);

    run_op(8'd54, 4'd9, lat);
    check("54_9_latency", lat, 8);
    check("54_9_quot", 32'(quotient), 6);
    check("54_9_rem",  32'(remainder), 0);

    run_op(8'd200, 4'd7, lat);
    check("200_7_quot", 32'(quotient), 28);
    check("200_7_rem",  32'(remainder), 4);
    run_op(8'd255, 4'd1, lat);
    check("255_1_quot", 32'(quotient), 255);
    check("255_1_rem",  32'(remainder), 0);
    run_op(8'd13, 4'd15, lat);
    check("13_15_quot", 32'(quotient), 0);
    check("13_15_rem",  32'(remainder), 13);

    run_op(8'd100, 4'd0, lat);
`ifdef SEQ_DIVIDER_DBZ_EN
    check("dbz_latency", lat, 1);
    check("dbz_flag", 32'(dbz), 1);
`else
    check("dbz_latency", lat, 8);
    check("dbz_flag", 32'(dbz), 0);
`endif
    check("dbz_quot", 32'(quotient), 255);
    check("dbz_rem",  32'(remainder), 4);

    // Start during RUN must be ignored; old result stays visible meanwhile.
    dividend = 8'd54;
    divisor  = 4'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("run_quot_stable", 32'(quotient), 255);
    lat = 3;
    while (!ready && lat < 20) begin
      tick();
      lat++;
    end
    check("ignore_latency", lat, 8);
    check("ignore_quot", 32'(quotient), 6);
    check("ignore_rem",  32'(remainder), 0);

    // Reset mid-run aborts and clears results.
    run_op(8'd200, 4'd7, lat);
    dividend = 8'd54;
    divisor  = 4'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(ready), 1);
    check("abort_quot",  32'(quotient), 0);
    check("abort_rem",   32'(remainder), 0);
    check("abort_dbz",   32'(dbz), 0);
    run_op(8'd54, 4'd9, lat);
    check("post_abort_quot", 32'(quotient), 6);
    check("post_abort_rem",  32'(remainder), 0);

    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        run_op(8'(dd), 4'(dv), lat);
        check("sweep_latency", lat, 8);
        check("sweep_quot", 32'(quotient), dd / dv);
        check("sweep_rem",  32'(remainder), dd % dv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
